// File: rtl/seg_display_pkg.sv
// rtl/seg_display_pkg.sv - shared types and segment constants for the result display scanner
package seg_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    // Segment order a..g maps to bit6..bit0, active-high.
    localparam logic [6:0] SEG_HEX_0 = 7'b1111110;
    localparam logic [6:0] SEG_HEX_1 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_2 = 7'b1101101;
    localparam logic [6:0] SEG_HEX_3 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_4 = 7'b0110011;
    localparam logic [6:0] SEG_HEX_5 = 7'b1011011;
    localparam logic [6:0] SEG_HEX_6 = 7'b1011111;
    localparam logic [6:0] SEG_HEX_7 = 7'b1110000;
    localparam logic [6:0] SEG_HEX_8 = 7'b1111111;
    localparam logic [6:0] SEG_HEX_9 = 7'b1111011;
    localparam logic [6:0] SEG_HEX_A = 7'b1110111;
    localparam logic [6:0] SEG_HEX_B = 7'b0011111;
    localparam logic [6:0] SEG_HEX_C = 7'b1001110;
    localparam logic [6:0] SEG_HEX_D = 7'b0111101;
    localparam logic [6:0] SEG_HEX_E = 7'b1001111;
    localparam logic [6:0] SEG_HEX_F = 7'b1000111;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_NEG   = 7'b0000001;
    localparam logic [6:0] SEG_POS   = 7'b0000000;

endpackage

// File: rtl/hex_to_seven_seg.sv
// rtl/hex_to_seven_seg.sv - combinational nibble to seven-segment encoder
module hex_to_seven_seg
    import seg_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/result_display_scan.sv
// rtl/result_display_scan.sv - captures a result word and scans its hex digits onto one segment bus
module result_display_scan
    import seg_display_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int DWELL  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        capture,
    input  logic [31:0] value,
    input  logic        signed_mode,
    input  logic        clear,
    output logic [6:0]  seg,
    output logic [6:0]  neg_seg,
    output logic [2:0]  digit_sel,
    output logic [7:0]  digit_en,
    output logic        busy,
    output logic        frame_done
);

    localparam int              DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [2:0]      LAST_DIGIT = 3'(DIGITS - 1);
    localparam logic [DW_W-1:0] LAST_DWELL = DW_W'(DWELL - 1);

    state_t          state, state_n;
    logic [31:0]     val, val_n;
    logic            smode, smode_n;
    logic            neg, neg_n;
    logic [31:0]     mag, mag_n;
    logic [2:0]      digit, digit_n;
    logic [DW_W-1:0] dwell, dwell_n;

    logic [3:0]      nibble_n;
    logic [6:0]      nibble_seg_n;
    logic            scan_n;
    logic [6:0]      seg_n, neg_seg_n;
    logic [2:0]      digit_sel_n;
    logic [7:0]      digit_en_n;
    logic            busy_n, frame_done_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            val        <= '0;
            smode      <= 1'b0;
            neg        <= 1'b0;
            mag        <= '0;
            digit      <= '0;
            dwell      <= '0;
            seg        <= SEG_BLANK;
            neg_seg    <= SEG_BLANK;
            digit_sel  <= '0;
            digit_en   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            val        <= val_n;
            smode      <= smode_n;
            neg        <= neg_n;
            mag        <= mag_n;
            digit      <= digit_n;
            dwell      <= dwell_n;
            seg        <= seg_n;
            neg_seg    <= neg_seg_n;
            digit_sel  <= digit_sel_n;
            digit_en   <= digit_en_n;
            busy       <= busy_n;
            frame_done <= frame_done_n;
        end
    end

    always_comb begin
        state_n = state;
        val_n   = val;
        smode_n = smode;
        neg_n   = neg;
        mag_n   = mag;
        digit_n = digit;
        dwell_n = dwell;
        if (clear) begin
            state_n = ST_IDLE;
            val_n   = '0;
            smode_n = 1'b0;
            neg_n   = 1'b0;
            mag_n   = '0;
            digit_n = '0;
            dwell_n = '0;
        end else if (capture) begin
            state_n = ST_LOAD;
            val_n   = value;
            smode_n = signed_mode;
            digit_n = '0;
            dwell_n = '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    neg_n   = smode & val[31];
                    mag_n   = (smode & val[31]) ? (~val + 32'd1) : val;
                    digit_n = '0;
                    dwell_n = '0;
                    state_n = ST_SCAN;
                end
                ST_SCAN: begin
                    if (dwell == LAST_DWELL) begin
                        dwell_n = '0;
                        digit_n = (digit == LAST_DIGIT) ? 3'd0 : digit + 3'd1;
                    end else begin
                        dwell_n = dwell + DW_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    assign nibble_n = 4'(mag_n >> {digit_n, 2'b00});

    hex_to_seven_seg u_hex_to_seven_seg (
        .nibble (nibble_n),
        .seg    (nibble_seg_n)
    );

    always_comb begin
        scan_n       = (state_n == ST_SCAN);
        seg_n        = scan_n ? nibble_seg_n : SEG_BLANK;
        neg_seg_n    = (scan_n && neg_n) ? SEG_NEG : SEG_POS;
        digit_sel_n  = scan_n ? digit_n : 3'd0;
        digit_en_n   = scan_n ? (8'd1 << digit_n) : 8'd0;
        busy_n       = (state_n != ST_IDLE);
        frame_done_n = scan_n && (digit_n == LAST_DIGIT) && (dwell_n == LAST_DWELL);
    end

endmodule

// File: tb/tb_result_display_scan.sv
// tb/tb_result_display_scan.sv - self-checking bench for result_display_scan
module tb_result_display_scan;

    localparam int DIGITS = 8;
    localparam int DWELL  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        capture = 1'b0;
    logic [31:0] value = '0;
    logic        signed_mode = 1'b0;
    logic        clear = 1'b0;
    logic [6:0]  seg, neg_seg;
    logic [2:0]  digit_sel;
    logic [7:0]  digit_en;
    logic        busy, frame_done;

    int total = 0;
    int bad   = 0;

    result_display_scan #(.DIGITS(DIGITS), .DWELL(DWELL)) dut (
        .clk         (clk),
        .rst         (rst),
        .capture     (capture),
        .value       (value),
        .signed_mode (signed_mode),
        .clear       (clear),
        .seg         (seg),
        .neg_seg     (neg_seg),
        .digit_sel   (digit_sel),
        .digit_en    (digit_en),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    // Model: mode 0 idle, 1 load, 2 scan; mk counts cycles since the scan started.
    int          mmode = 0;
    logic [31:0] mword = '0;
    logic        msigned = 1'b0;
    int          mk = 0;
    bit          armed = 1'b0;

    always @(posedge clk) begin
        if (rst || clear) begin
            mmode = 0;
        end else if (capture) begin
            mmode   = 1;
            mword   = value;
            msigned = signed_mode;
        end else if (mmode == 1) begin
            mmode = 2;
            mk    = 0;
        end else if (mmode == 2) begin
            mk = mk + 1;
        end
        armed = 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            logic [6:0]  e_seg, e_neg;
            logic [2:0]  e_sel;
            logic [7:0]  e_en;
            logic        e_busy, e_fd, is_neg;
            logic [31:0] m;
            int          d;
            e_seg = 7'b0; e_neg = 7'b0; e_sel = 3'd0; e_en = 8'd0; e_fd = 1'b0;
            e_busy = (mmode != 0);
            if (mmode == 2) begin
                is_neg = msigned && mword[31];
                m      = is_neg ? (32'd0 - mword) : mword;
                d      = (mk / DWELL) % DIGITS;
                e_seg  = hex_tab[(m >> (4 * d)) & 32'hF];
                e_neg  = is_neg ? 7'b0000001 : 7'b0000000;
                e_sel  = 3'(d);
                e_en   = 8'(1 << d);
                e_fd   = ((mk % (DWELL * DIGITS)) == DWELL * DIGITS - 1);
            end
            total = total + 1;
            if ({seg, neg_seg, digit_sel, digit_en, busy, frame_done} !==
                {e_seg, e_neg, e_sel, e_en, e_busy, e_fd}) begin
                bad = bad + 1;
                $display("FAIL model_cycle t=%0t got seg=%b neg=%b sel=%0d en=%b busy=%b fd=%b exp seg=%b neg=%b sel=%0d en=%b busy=%b fd=%b",
                         $time, seg, neg_seg, digit_sel, digit_en, busy, frame_done,
                         e_seg, e_neg, e_sel, e_en, e_busy, e_fd);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Returns positioned on the first scan cycle (digit 0, fresh dwell).
    task automatic do_capture(input logic [31:0] v, input logic s);
        capture = 1'b1; value = v; signed_mode = s;
        cyc(1);
        capture = 1'b0;
        check("load_busy", 32'(busy), 32'd1);
        cyc(1);
    endtask

    initial begin
        cyc(3);
        check("reset_seg", 32'(seg), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        cyc(1);

        do_capture(32'h0000001F, 1'b0);
        check("u1f_d0_seg", 32'(seg), 32'b1000111);
        check("u1f_d0_en", 32'(digit_en), 32'b00000001);
        cyc(3);
        check("u1f_d0_hold", 32'(digit_en), 32'b00000001);
        cyc(1);
        check("u1f_d1_seg", 32'(seg), 32'b0110000);
        cyc(27);
        check("u1f_frame_done", 32'(frame_done), 32'd1);
        check("u1f_last_sel", 32'(digit_sel), 32'd7);
        cyc(1);
        check("u1f_wrap_sel", 32'(digit_sel), 32'd0);
        check("u1f_wrap_fd", 32'(frame_done), 32'd0);

        cyc(5);
        rst = 1'b1;
        cyc(1);
        check("rst_mid_seg", 32'(seg), 32'd0);
        check("rst_mid_en", 32'(digit_en), 32'd0);
        cyc(2);
        capture = 1'b1; value = 32'h5;
        cyc(1);
        rst = 1'b0; capture = 1'b0;
        check("rst_cap_busy", 32'(busy), 32'd0);
        cyc(2);
        check("rst_cap_idle", 32'(busy), 32'd0);

        do_capture(32'hFFFFFFFE, 1'b1);
        check("sfe_neg", 32'(neg_seg), 32'b0000001);
        check("sfe_d0", 32'(seg), 32'b1101101);
        cyc(4);
        check("sfe_d1", 32'(seg), 32'b1111110);
        cyc(30);

        do_capture(32'h80000000, 1'b1);
        check("s80_neg", 32'(neg_seg), 32'b0000001);
        check("s80_d0", 32'(seg), 32'b1111110);
        cyc(28);
        check("s80_d7", 32'(seg), 32'b1111111);
        do_capture(32'h80000000, 1'b0);
        check("u80_neg", 32'(neg_seg), 32'b0000000);
        cyc(28);
        check("u80_d7", 32'(seg), 32'b1111111);

        do_capture(32'h12345678, 1'b0);
        cyc(13);
        check("re_d3", 32'(digit_sel), 32'd3);
        do_capture(32'hABCD0000, 1'b0);
        check("re_d0_seg", 32'(seg), 32'b1111110);
        check("re_d0_en", 32'(digit_en), 32'b00000001);
        cyc(3);
        check("re_d0_dwell", 32'(digit_sel), 32'd0);
        cyc(1);
        check("re_d1", 32'(digit_sel), 32'd1);
        cyc(12);
        check("re_d4", 32'(seg), 32'b0111101);
        cyc(4);
        check("re_d5", 32'(seg), 32'b1001110);
        cyc(4);
        check("re_d6", 32'(seg), 32'b0011111);
        cyc(4);
        check("re_d7", 32'(seg), 32'b1110111);

        cyc(2);
        clear = 1'b1; capture = 1'b1; value = 32'h7;
        cyc(1);
        clear = 1'b0; capture = 1'b0;
        check("clr_seg", 32'(seg), 32'd0);
        check("clr_en", 32'(digit_en), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        cyc(2);
        check("clr_stay", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
